// File: rtl/remora_pkg.sv
// remora_pkg: shared encodings and defaults for the quadrature encoder input stage
package remora_pkg;
  typedef enum logic [1:0] {QS_00 = 2'b00, QS_01 = 2'b01, QS_11 = 2'b11, QS_10 = 2'b10} qstate_t;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} fsm_t;
  localparam int DEFAULT_FILTER_LEN = 4;
  localparam int INIT_CYCLES = 3;
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;
  localparam logic [1:0] DIR_ILL  = 2'b11;
  function automatic logic [1:0] quad_dir(input qstate_t p, input qstate_t c);
    logic fwd;
    fwd = (p == QS_00 && c == QS_01) || (p == QS_01 && c == QS_11) ||
          (p == QS_11 && c == QS_10) || (p == QS_10 && c == QS_00);
    return ((p ^ c) == 2'b11) ? DIR_ILL : fwd ? DIR_FWD : (p != c) ? DIR_REV : DIR_HOLD;
  endfunction
endpackage

// File: rtl/input_filter.sv
// input_filter: 2-FF synchroniser plus consecutive-sample glitch filter with direct load during INIT
module input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  input  logic i_load,
  output logic o_filt,
  output logic o_s2
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
  logic r_s1, r_s2, r_filt;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      if (i_load) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
  assign o_filt = r_filt;
  assign o_s2   = r_s2;
endmodule

// File: rtl/quad_encoder.sv
// quad_encoder: filtered 4x quadrature decoder with index-latched position and sticky error flag
module quad_encoder
  import remora_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             QUAD_A,
  input  logic             QUAD_B,
  input  logic             QUAD_Z,
  input  logic             indexEnable,
  input  logic             errClear,
  output logic [WIDTH-1:0] position,
  output logic [WIDTH-1:0] indexPosition,
  output logic             indexSeen,
  output logic             error
);
  fsm_t r_state, w_state_nxt;
  logic [1:0] r_init_cnt, w_init_cnt_nxt;
  logic w_load, w_run;
  logic w_filt_a, w_filt_b, w_filt_z, w_s2_a, w_s2_b, w_s2_z;
  qstate_t r_cur_ab, r_prev_ab;
  logic r_cur_z, r_prev_z;
  logic [1:0] w_dir;
  logic [WIDTH-1:0] r_position, r_index_pos, w_pos_nxt;
  logic r_index_seen, r_error, w_capture;
  assign w_load = r_state == INIT;
  assign w_run  = r_state == RUN;
  input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .i_pin(QUAD_A), .i_load(w_load), .o_filt(w_filt_a), .o_s2(w_s2_a)
  );
  input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .i_pin(QUAD_B), .i_load(w_load), .o_filt(w_filt_b), .o_s2(w_s2_b)
  );
  input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clk(clk), .rst(rst), .i_pin(QUAD_Z), .i_load(w_load), .o_filt(w_filt_z), .o_s2(w_s2_z)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    if (r_state == INIT) begin
      w_init_cnt_nxt = r_init_cnt + 2'd1;
      w_state_nxt    = (r_init_cnt == 2'(INIT_CYCLES - 1)) ? RUN : INIT;
    end
  end
  // INIT seeds the edge pipeline from the filters' incoming value so pins already high never look like a transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_ab  <= QS_00;
      r_prev_ab <= QS_00;
      r_cur_z   <= 1'b0;
      r_prev_z  <= 1'b0;
    end else if (w_load) begin
      r_cur_ab  <= qstate_t'({w_s2_a, w_s2_b});
      r_prev_ab <= qstate_t'({w_s2_a, w_s2_b});
      r_cur_z   <= w_s2_z;
      r_prev_z  <= w_s2_z;
    end else begin
      r_cur_ab  <= qstate_t'({w_filt_a, w_filt_b});
      r_prev_ab <= r_cur_ab;
      r_cur_z   <= w_filt_z;
      r_prev_z  <= r_cur_z;
    end
  end
  assign w_dir     = w_run ? quad_dir(r_prev_ab, r_cur_ab) : DIR_HOLD;
  assign w_pos_nxt = (w_dir == DIR_FWD) ? r_position + WIDTH'(1) :
                     (w_dir == DIR_REV) ? r_position - WIDTH'(1) : r_position;
  assign w_capture = w_run && r_cur_z && !r_prev_z && indexEnable && !r_index_seen;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_position   <= '0;
      r_index_pos  <= '0;
      r_index_seen <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_position   <= w_pos_nxt;
      r_index_pos  <= w_capture ? w_pos_nxt : r_index_pos;
      r_index_seen <= !indexEnable ? 1'b0 : (w_capture ? 1'b1 : r_index_seen);
      r_error      <= (w_dir == DIR_ILL) ? 1'b1 : (errClear ? 1'b0 : r_error);
    end
  end
  assign position      = r_position;
  assign indexPosition = r_index_pos;
  assign indexSeen     = r_index_seen;
  assign error         = r_error;
endmodule

// File: tb/tb_quad_encoder.sv
// tb_quad_encoder: directed table-driven checks of decode, filtering, index capture, error and wrap
module tb_quad_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0, b = 1'b0, z = 1'b0, ien = 1'b0, eclr = 1'b0;
  logic [31:0] pos, ipos;
  logic iseen, err;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic a;
    logic b;
    logic [31:0] pos;
    logic err;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  quad_encoder #(.WIDTH(32), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .QUAD_A(a), .QUAD_B(b), .QUAD_Z(z),
    .indexEnable(ien), .errClear(eclr),
    .position(pos), .indexPosition(ipos), .indexSeen(iseen), .error(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input logic na, input logic nb, input logic nz);
    a = na;
    b = nb;
    z = nz;
    cyc(10);
  endtask

  task automatic do_reset(input logic ra, input logic rb);
    rst = 1'b1;
    a = ra;
    b = rb;
    z = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'd2, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'd3, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'd4, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'd5, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'd6, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'd7, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'd8, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'd7, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'd6, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'd5, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'd4, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 32'd4, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'd5, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'd6, 1'b1};

    a = 1'b1;
    b = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset_pos", pos, 32'd0);
    chk("reset_ipos", ipos, 32'd0);
    chk("reset_iseen", {31'd0, iseen}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    cyc(3);
    rst = 1'b0;
    cyc(10);
    chk("high_release_pos", pos, 32'd0);
    chk("high_release_err", {31'd0, err}, 32'd0);

    do_reset(1'b0, 1'b0);
    b = 1'b1;
    cyc(7);
    chk("latency_before", pos, 32'd0);
    cyc(1);
    chk("latency_at", pos, 32'd1);
    cyc(2);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].a, tbl[i].b, 1'b0);
      chk($sformatf("vec%0d_pos", i), pos, tbl[i].pos);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
    end

    eclr = 1'b1;
    cyc(1);
    eclr = 1'b0;
    chk("errclear", {31'd0, err}, 32'd0);
    a = 1'b1;
    b = 1'b1;
    cyc(7);
    eclr = 1'b1;
    cyc(1);
    eclr = 1'b0;
    chk("set_wins_err", {31'd0, err}, 32'd1);
    chk("set_wins_pos", pos, 32'd6);
    cyc(3);
    eclr = 1'b1;
    cyc(1);
    eclr = 1'b0;
    chk("errclear2", {31'd0, err}, 32'd0);

    a = 1'b0;
    cyc(3);
    a = 1'b1;
    cyc(10);
    chk("glitch3_pos", pos, 32'd6);
    a = 1'b0;
    cyc(4);
    a = 1'b1;
    cyc(5);
    chk("pulse4_mid", pos, 32'd5);
    cyc(10);
    chk("pulse4_end", pos, 32'd6);
    chk("pulse4_err", {31'd0, err}, 32'd0);

    do_reset(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rev1", pos, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("rev3", pos, 32'hFFFF_FFFD);
    force dut.r_position = 32'h7FFF_FFFF;
    cyc(1);
    release dut.r_position;
    cyc(1);
    chk("preload", pos, 32'h7FFF_FFFF);
    step(1'b1, 1'b1, 1'b0);
    chk("wrap_pos", pos, 32'h8000_0000);

    do_reset(1'b0, 1'b0);
    ien = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("idx_pre_pos", pos, 32'd5);
    chk("idx_pre_seen", {31'd0, iseen}, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("idx_cap_pos", ipos, 32'd6);
    chk("idx_cap_seen", {31'd0, iseen}, 32'd1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("idx_second_count", pos, 32'd9);
    chk("idx_second_hold", ipos, 32'd6);
    ien = 1'b0;
    cyc(1);
    chk("idx_disable_seen", {31'd0, iseen}, 32'd0);
    chk("idx_disable_ipos", ipos, 32'd6);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("idx_disabled_seen", {31'd0, iseen}, 32'd0);
    chk("idx_disabled_ipos", ipos, 32'd6);

    a = 1'b1;
    b = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_pos", pos, 32'd0);
    chk("midrst_ipos", ipos, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk("midrst_release_pos", pos, 32'd0);
    chk("midrst_release_err", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
